// File: rtl/mux4_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_arbiter
//  Purpose  : Round-robin arbiter and 4:1 sequencer for a 24-bit data path,
//             streaming bounded bursts from the granted source over valid/ready.
//  Revision : 1.0
// ============================================================================
module mux4_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [23:0] d0,
    input  logic [23:0] d1,
    input  logic [23:0] d2,
    input  logic [23:0] d3,
    input  logic        out_ready,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic        out_valid,
    output logic [23:0] out_data,
    output logic        busy
);

    localparam int c_cnt_w = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_ptr;
    logic [1:0]           w_ptr_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [3:0]           r_gnt;
    logic [3:0]           w_gnt_nxt;
    logic [1:0]           r_sel;
    logic [1:0]           w_sel_nxt;
    logic [1:0]           w_pick;
    logic [23:0]          w_src;
    logic                 w_busy;
    logic                 w_accept;

    assign w_busy    = (r_state == ST_BUSY);
    assign busy      = w_busy;
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_valid = w_busy & req[r_sel];
    assign w_accept  = out_valid & out_ready;
    assign out_data  = w_busy ? w_src : 24'h0;

    always_comb begin
        w_src = d0;
        case (r_sel)
            2'd0:    w_src = d0;
            2'd1:    w_src = d1;
            2'd2:    w_src = d2;
            default: w_src = d3;
        endcase
    end

    // Scan from farthest to nearest so the nearest requester (from ptr) wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_pick = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_pick;
                    w_gnt_nxt   = 4'b0001 << w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                // A withdrawn request has out_valid low, so no beat is counted.
                if (!req[r_sel] || (w_accept && (r_cnt == c_last))) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_gnt_nxt   = 4'b0000;
                    w_cnt_nxt   = '0;
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_arbiter
//  Purpose  : Scoreboard bench for mux4_arbiter with a transaction-level model.
//  Revision : 1.0
// ============================================================================
module tb_mux4_arbiter;

    localparam int BURST_MAX = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [23:0] dd [4];
    logic        out_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [23:0] out_data;
    logic        busy;

    mux4_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (dd[0]),
        .d1        (dd[1]),
        .d2        (dd[2]),
        .d3        (dd[3]),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        busy;
        logic        valid;
        logic [23:0] data;
    } exp_t;

    exp_t q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: owner of the bus (-1 when idle), beats taken, next-priority source.
    int m_own = -1;
    int m_cnt = 0;
    int m_ptr = 0;
    int m_sel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, want);
        end
    endtask

    task automatic model_release();
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
        m_cnt = 0;
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy, input logic rs, input bit rnd);
        exp_t e;
        @(negedge clk);
        rst       = rs;
        req       = r;
        out_ready = rdy;
        if (rnd) begin
            for (int i = 0; i < 4; i++) begin
                if (!r[i]) dd[i] = 24'($urandom);
            end
        end
        e.busy  = (m_own >= 0);
        e.sel   = 2'(m_sel);
        e.gnt   = 4'b0000;
        e.valid = 1'b0;
        e.data  = 24'h0;
        if (m_own >= 0) begin
            e.gnt   = 4'(1 << m_own);
            e.valid = r[m_own];
            e.data  = dd[m_own];
        end
        q.push_back(e);
        if (rs) begin
            m_own = -1; m_cnt = 0; m_ptr = 0; m_sel = 0;
        end else if (m_own < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_own < 0 && r[(m_ptr + k) % 4]) begin
                    m_own = (m_ptr + k) % 4;
                end
            end
            if (m_own >= 0) begin
                m_sel = m_own;
                m_cnt = 0;
            end
        end else if (!r[m_own]) begin
            model_release();
        end else if (rdy) begin
            m_cnt++;
            if (m_cnt == BURST_MAX) model_release();
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt",       32'(gnt),       32'(e.gnt));
                chk("sel",       32'(sel),       32'(e.sel));
                chk("busy",      32'(busy),      32'(e.busy));
                chk("out_valid", 32'(out_valid), 32'(e.valid));
                chk("out_data",  32'(out_data),  32'(e.data));
            end
        end
    end

    initial begin
        logic [3:0] r;
        rst       = 1'b1;
        req       = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) dd[i] = 24'h100000 * 24'(i + 1) + 24'h11;

        // Reset held with everything requesting, then fairness round.
        drive(4'hF, 1'b1, 1'b1, 1'b0);
        drive(4'hF, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 26; c++) drive(4'hF, 1'b1, 1'b0, 1'b0);

        // Single source with fixed data.
        drive(4'h0, 1'b1, 1'b1, 1'b0);
        dd[2] = 24'hABCDEF;
        for (int c = 0; c < 12; c++) drive(4'b0100, 1'b1, 1'b0, 1'b0);

        // Backpressure on source 1.
        drive(4'h0, 1'b1, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) drive(4'b0010, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) drive(4'b0010, 1'b1, 1'b0, 1'b0);

        // Early withdrawal of source 1 after two beats.
        drive(4'h0, 1'b1, 1'b1, 1'b0);
        drive(4'b1010, 1'b1, 1'b0, 1'b0);
        drive(4'b1010, 1'b1, 1'b0, 1'b0);
        drive(4'b1010, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) drive(4'b1000, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a burst from source 2.
        drive(4'h0, 1'b1, 1'b1, 1'b0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        drive(4'b1100, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) drive(4'b1100, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with sticky requests and occasional reset.
        r = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            end
            drive(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0), 1'b1);
        end

        @(negedge clk);
        @(negedge clk);
        #4;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer for a shared 24-bit, four-source data path. Four requesters present data and a request. The block grants one requester at a time and drives the 4:1 select. It streams that requester's beats out over a valid/ready handshake and limits each grant to a bounded burst so no requester starves. It sits between the processor's four 24-bit producers and the single downstream consumer of the muxed bus.

## Interface
- BURST_MAX, default 4: maximum beats accepted per grant; legal range 1..16.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request per source; bit i belongs to d{i}
- d0  input  24  source 0 data
- d1  input  24  source 1 data
- d2  input  24  source 2 data
- d3  input  24  source 3 data
- out_ready  input  1  consumer accepts the current beat
- gnt  output  4  one-hot grant, registered; 0 when idle
- sel  output  2  mux select / index of granted source, registered
- out_valid  output  1  beat available: busy & req[sel]
- out_data  output  24  d[sel] when busy, else 24'h0
- busy  output  1  a grant is active (FSM in BUSY)

## Operation
- Two states: IDLE and BUSY. Internal state consists of:
  - rotating priority pointer ptr[1:0];
  - beat counter cnt, wide enough for BURST_MAX.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load sel and gnt with that index, clear cnt, go to BUSY.
  - If req == 0, stay in IDLE.
- BUSY:
  - A beat is accepted on an edge where out_valid & out_ready.
  - On acceptance, cnt increments.
  - Release occurs when either condition holds:
    - an accepted beat has cnt == BURST_MAX-1;
    - req[sel] == 0 on the edge (requester withdrew).
  - On release: ptr = sel+1 (mod 4), gnt = 0, cnt = 0, go to IDLE.
- The grant holds through backpressure. With out_ready low, gnt, sel and cnt are unchanged.
- Requester obligation: keep d{i} stable while req[i] is high and the beat is not accepted. The block does not latch data.
- out_data and out_valid are combinational from the registered sel/busy and the live req and d inputs.
- Reset values:
  - state = IDLE, ptr = 0, cnt = 0, gnt = 4'b0000, sel = 2'b00, busy = 0.
  - Therefore out_valid = 0 and out_data = 24'h0.
- Reset mid-burst: the next edge forces all reset values. An unaccepted beat is dropped, and ptr returns to 0.
- BURST_MAX = 1: exactly one beat per grant.

## Timing
- Request to grant: req sampled high at edge k in IDLE, gnt/sel/busy valid after edge k. The earliest beat is accepted at edge k+1.
- Re-arbitration costs one idle bubble. Release at edge k puts the block in IDLE during cycle k+1, and the new grant is visible after edge k+1.
- Back-to-back full bursts from one source: BURST_MAX beats, one bubble, repeat. Throughput is BURST_MAX/(BURST_MAX+1).
- Worst-case wait for a continuously requesting source, with out_ready held high: 3 × (BURST_MAX+1) + 1 cycles from its req rising to its gnt.
- Simultaneous events:
  - Release and a new req on the same edge: the new req is evaluated in the following IDLE cycle.
  - A withdrawing requester whose req drops on the edge it would otherwise transfer: no beat is counted.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=4'hF and out_ready=1.
  - During reset: gnt=0, out_valid=0, out_data=0.
  - First edge after release: gnt=4'b0001, sel=0.
- Single source: BURST_MAX=4, req=4'b0100 constant, d2=24'hABCDEF, out_ready=1.
  - Four accepted beats of 24'hABCDEF with sel=2.
  - One cycle with gnt=0, then gnt=4'b0100 again.
- Fairness: BURST_MAX=4, req=4'hF constant, out_ready=1.
  - Grant order 0,1,2,3,0.
  - Each grant gives exactly 4 beats followed by one bubble, and out_data equals d[sel] on every beat.
- Backpressure: source 1 granted, out_ready=0 for 5 cycles, then 1.
  - During the stall: out_valid=1, gnt=4'b0010 and out_data stable, with no beat counted.
  - After the stall: the burst completes at 4 beats total.
- Early withdrawal: req=4'b1010, BURST_MAX=4, source 1 granted.
  - Source 1 drops req after 2 accepted beats.
  - Release on that edge, ptr=2, then gnt=4'b1000 after the bubble.
- Reset mid-burst: source 2 granted with cnt=2, then pulse rst for 1 cycle with req=4'b1100.
  - Next edge: gnt=0, busy=0.
  - After rst falls: gnt=4'b0100 (ptr=0 scan reaches 2 first).
